// File: rtl/shift_add_mul4.sv
// ---------------------------------------------------------------------------
// shift_add_mul4
//   Sequential unsigned multiplier. It adds and shifts right once per cycle,
//   so a multiply takes DATA_W iterations. Operands are captured when start
//   is accepted. The product register holds its value until the next result
//   is written.
//
// Ports
//   clk    : rising-edge clock for all state
//   rst_n  : asynchronous active-low reset; clears FSM, datapath and outputs
//   start  : start request; accepted in IDLE or DONE, ignored while busy
//   A      : multiplicand (unsigned), captured on the accepting edge
//   B      : multiplier (unsigned), captured on the accepting edge
//   P      : registered product A*B
//   busy   : high while iterating (RUN)
//   done   : one-cycle pulse; P holds a new result
// ---------------------------------------------------------------------------
module shift_add_mul4 #(
   parameter int DATA_W = 4
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  start,
   input  logic [DATA_W-1:0]     A,
   input  logic [DATA_W-1:0]     B,
   output logic [2*DATA_W-1:0]   P,
   output logic                  busy,
   output logic                  done
);

   localparam int CNT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
   localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(DATA_W - 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t state, next_state;

   logic [DATA_W-1:0] mcand;
   logic [DATA_W-1:0] acc;
   logic [DATA_W-1:0] mq;
   logic [CNT_W-1:0]  cnt;
   logic [DATA_W:0]   sum;
   logic              accept;
   logic              last_iter;

   // A start request is accepted only when no multiply is in flight.
   assign accept    = start && (state != RUN);
   assign last_iter = (state == RUN) && (cnt == LAST_ITER);

   // The add keeps its carry-out in sum[DATA_W]. That carry becomes the MSB
   // of the shifted {acc,mq} pair, so no product bit is lost.
   always_comb begin
      sum = {1'b0, acc} + (mq[0] ? {1'b0, mcand} : {(DATA_W+1){1'b0}});
   end

   // ---- FSM state register ----
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
      end else begin
         state <= next_state;
      end
   end

   // ---- FSM next-state logic ----
   always_comb begin
      next_state = state;
      unique case (state)
         IDLE:    next_state = start ? RUN : IDLE;
         RUN:     next_state = (cnt == LAST_ITER) ? DONE : RUN;
         DONE:    next_state = start ? RUN : IDLE;
         default: next_state = IDLE;
      endcase
   end

   // ---- FSM outputs ----
   always_comb begin
      busy = (state == RUN);
      done = (state == DONE);
   end

   // ---- Datapath: operand capture, iteration, result write ----
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mcand <= '0;
         acc   <= '0;
         mq    <= '0;
         cnt   <= '0;
         P     <= '0;
      end else if (accept) begin
         mcand <= A;
         mq    <= B;
         acc   <= '0;
         cnt   <= '0;
      end else if (state == RUN) begin
         // Shift {carry,acc,mq} right by one. The bit dropped from mq has
         // been used as the current multiplier bit.
         {acc, mq} <= {sum, mq[DATA_W-1:1]};
         cnt       <= cnt + 1'b1;
         if (last_iter) begin
            P <= {sum, mq[DATA_W-1:1]};
         end
      end
   end

endmodule

// File: doc/shift_add_mul4.md
SHIFT_ADD_MUL4 -- requirements
Module: shift_add_mul4

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset. Ports are named clk and rst_n.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 rst_n  input  1  asynchronous, active-low reset; clears all state immediately.
REQ-004 start  input  1  request to start a multiply; sampled on the rising edge of clk.
REQ-005 A  input  4  multiplicand, unsigned; captured on the edge where start is accepted.
REQ-006 B  input  4  multiplier, unsigned; captured on the edge where start is accepted.
REQ-007 P  output  8  product A*B, unsigned; registered; holds its value until the next result is written.
REQ-008 busy  output  1  high while an accepted multiply is iterating (RUN state).
REQ-009 done  output  1  one-cycle pulse marking that P holds a new result.

Function
REQ-010 The block SHALL use a 3-state FSM with states IDLE, RUN and DONE.
REQ-011 Internal datapath registers:
- mcand[3:0]: latched A.
- acc[3:0]: high partial product.
- mq[3:0]: multiplier / low partial product.
- cnt[1:0]: iteration count.
REQ-012 Start acceptance: in IDLE or DONE, start=1 at a rising edge SHALL:
- latch mcand=A and mq=B;
- clear acc=0 and cnt=0;
- move the FSM to RUN.
REQ-013 In RUN, each edge SHALL perform one iteration:
- sum[4:0] = acc + (mq[0] ? mcand : 0), as a 4-bit add with carry-in 0 and carry-out in sum[4];
- {acc,mq} <= {sum[4:0],mq[3:1]}, a right shift of the 9-bit {carry,acc,mq};
- cnt <= cnt+1.
REQ-014 The edge that performs the 4th iteration (cnt=3) SHALL:
- write P <= {sum[4:0],mq[3:1]};
- move the FSM to DONE.
REQ-015 Latency: if start is accepted at edge N, iterations occur at edges N+1..N+4, and P and done become valid after edge N+4.
REQ-016 busy SHALL be 1 exactly while the FSM is in RUN, i.e. from after edge N to after edge N+4.
REQ-017 done SHALL be 1 exactly while the FSM is in DONE, which lasts one cycle.
REQ-018 DONE -> RUN when start=1, giving back-to-back operation with no idle cycle. DONE -> IDLE when start=0.
REQ-019 IDLE SHALL remain in IDLE while start=0.
REQ-020 start asserted while in RUN SHALL be ignored, and A/B changes during RUN SHALL NOT affect the result in progress.
REQ-021 The product SHALL be exact for all 256 operand pairs. The maximum is 15*15=225=8'hE1, so no overflow output exists.
REQ-022 P SHALL change only at the 4th-iteration edge or on reset, never during RUN.
REQ-023 Operands of zero SHALL still take the full 4 iterations with no early termination.

Reset
REQ-024 While rst_n=0, the following SHALL be forced asynchronously:
- FSM = IDLE;
- P = 8'h00;
- busy = 0 and done = 0;
- acc, mq, mcand and cnt = 0.
REQ-025 Reset asserted mid-RUN SHALL abort the operation. No done pulse is produced, and P reads 8'h00.
REQ-026 After rst_n deasserts, the first rising edge with start=1 SHALL be accepted normally.

Verification
REQ-027 A=4'hF, B=4'hF, start pulsed 1 cycle -> busy high for 4 cycles, then done=1 for one cycle with P=8'hE1.
REQ-028 A=4'h0, B=4'h0 -> done after 4 cycles with P=8'h00. Then A=4'h1, B=4'hF -> P=8'h0F. Then A=4'hA, B=4'hC -> P=8'h78.
REQ-029 start for A=3, B=5, then start re-pulsed with A=7, B=7 while busy -> ignored; P=8'h0F and a single done pulse.
REQ-030 start held high continuously with A=2, B=3 -> done pulses every 5 cycles, DONE->RUN with no IDLE cycle, and P=8'h06 each time.
REQ-031 rst_n pulled low after the 2nd iteration of 9*9 -> P=8'h00, busy=0 and done=0 immediately, with no later done pulse. A following 9*9 yields P=8'h51.
REQ-032 Exhaustive sweep of all 256 A/B pairs -> P equals A*B at every done pulse, and the latency is always 4 cycles from start acceptance.
